// File: rtl/bcd_tick_counter_if.sv
// Control and display signals of the two-digit BCD tick counter.
// The master drives the divider input and controls; the slave returns digits and segments.
interface bcd_tick_counter_if;
  logic       div_in;
  logic       start;
  logic       stop;
  logic       clear;
  logic       up_dn;
  logic [3:0] ones;
  logic [3:0] tens;
  logic       running;
  logic       wrap;
  logic [6:0] seg_ones;
  logic [6:0] seg_tens;

  modport master (
    output div_in, start, stop, clear, up_dn,
    input  ones, tens, running, wrap, seg_ones, seg_tens
  );

  modport slave (
    input  div_in, start, stop, clear, up_dn,
    output ones, tens, running, wrap, seg_ones, seg_tens
  );
endinterface

// File: rtl/bcd_tick_counter.sv
// Two-digit BCD counter of rising edges on the divided clock, with run/pause control,
// up/down counting, a rollover pulse and registered active-low 7-segment patterns.
module bcd_tick_counter #(
  parameter int unsigned MAX_VAL = 59
) (
  input  logic               clk,
  input  logic               rst,
  bcd_tick_counter_if.slave  bus
);

  localparam logic [3:0] MAX_TENS = 4'(MAX_VAL / 10);
  localparam logic [3:0] MAX_ONES = 4'(MAX_VAL % 10);
  localparam logic [6:0] SEG_ZERO = 7'b1000000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t     state_r;
  state_t     next_state_s;
  logic       div_prev_r;
  logic       tick_s;
  logic       count_en_s;
  logic       wrap_s;
  logic [3:0] ones_r;
  logic [3:0] tens_r;
  logic [3:0] ones_nx_s;
  logic [3:0] tens_nx_s;
  logic       running_r;
  logic       wrap_r;
  logic [6:0] seg_ones_r;
  logic [6:0] seg_tens_r;

  // Active-low {g,f,e,d,c,b,a}; codes above 9 blank the digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  // Next state with control priority clear > stop > start.
  always_comb begin
    next_state_s = state_r;
    if (bus.clear) begin
      next_state_s = IDLE;
    end else if (bus.stop) begin
      if (state_r == RUN) begin
        next_state_s = PAUSE;
      end else begin
        next_state_s = state_r;
      end
    end else if (bus.start) begin
      next_state_s = RUN;
    end else begin
      next_state_s = state_r;
    end
  end

  // Next digit values; a tick coinciding with clear or stop is dropped.
  always_comb begin
    tick_s     = bus.div_in & ~div_prev_r;
    count_en_s = (state_r == RUN) & tick_s & ~bus.clear & ~bus.stop;
    ones_nx_s  = ones_r;
    tens_nx_s  = tens_r;
    wrap_s     = 1'b0;
    if (count_en_s) begin
      if (bus.up_dn) begin
        if ((tens_r == MAX_TENS) && (ones_r == MAX_ONES)) begin
          ones_nx_s = 4'd0;
          tens_nx_s = 4'd0;
          wrap_s    = 1'b1;
        end else if (ones_r == 4'd9) begin
          ones_nx_s = 4'd0;
          tens_nx_s = tens_r + 4'd1;
        end else begin
          ones_nx_s = ones_r + 4'd1;
        end
      end else begin
        if ((tens_r == 4'd0) && (ones_r == 4'd0)) begin
          ones_nx_s = MAX_ONES;
          tens_nx_s = MAX_TENS;
          wrap_s    = 1'b1;
        end else if (ones_r == 4'd0) begin
          ones_nx_s = 4'd9;
          tens_nx_s = tens_r - 4'd1;
        end else begin
          ones_nx_s = ones_r - 4'd1;
        end
      end
    end else begin
      ones_nx_s = ones_r;
      tens_nx_s = tens_r;
    end
  end

  // State, digits and all outputs; div_prev resets high so a level already high is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      div_prev_r <= 1'b1;
      ones_r     <= 4'd0;
      tens_r     <= 4'd0;
      running_r  <= 1'b0;
      wrap_r     <= 1'b0;
      seg_ones_r <= SEG_ZERO;
      seg_tens_r <= SEG_ZERO;
    end else begin
      state_r    <= next_state_s;
      div_prev_r <= bus.div_in;
      running_r  <= (next_state_s == RUN);
      wrap_r     <= wrap_s;
      seg_ones_r <= seg_decode(ones_r);
      seg_tens_r <= seg_decode(tens_r);
      if (bus.clear) begin
        ones_r <= 4'd0;
        tens_r <= 4'd0;
      end else begin
        ones_r <= ones_nx_s;
        tens_r <= tens_nx_s;
      end
    end
  end

  assign bus.ones     = ones_r;
  assign bus.tens     = tens_r;
  assign bus.running  = running_r;
  assign bus.wrap     = wrap_r;
  assign bus.seg_ones = seg_ones_r;
  assign bus.seg_tens = seg_tens_r;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Bench for bcd_tick_counter: directed scenarios plus randomized traffic, each checked
// against an integer-valued model of the counter kept alongside the DUT.
module tb_bcd_tick_counter;

  localparam int MAX_VAL = 59;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  bcd_tick_counter_if bus ();

  bcd_tick_counter #(.MAX_VAL(MAX_VAL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: count as a plain integer; mode 0 idle, 1 run, 2 pause.
  int   m_val;
  int   m_mode;
  bit   m_prev;
  bit   m_wrap;
  bit   m_run;
  int   m_seg_t;
  int   m_seg_o;

  logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  function automatic logic [23:0] got();
    return {bus.tens, bus.ones, bus.running, bus.wrap, bus.seg_tens, bus.seg_ones};
  endfunction

  function automatic logic [23:0] exp_vec();
    return {4'(m_val / 10), 4'(m_val % 10), m_run, m_wrap, seg_tab[m_seg_t], seg_tab[m_seg_o]};
  endfunction

  // One clock: drive inputs, take the edge, advance the model, then sample point is #1 later.
  task automatic cyc(input bit r, input bit d, input bit st, input bit sp, input bit cl, input bit ud);
    bit tick;
    rst = r; bus.div_in = d; bus.start = st; bus.stop = sp; bus.clear = cl; bus.up_dn = ud;
    @(posedge clk);
    tick    = d && !m_prev;
    m_seg_t = m_val / 10;
    m_seg_o = m_val % 10;
    if (r) begin
      m_val = 0; m_mode = 0; m_prev = 1'b1; m_wrap = 1'b0; m_run = 1'b0;
      m_seg_t = 0; m_seg_o = 0;
    end else begin
      m_prev = d;
      m_wrap = 1'b0;
      if (m_mode == 1 && tick && !cl && !sp) begin
        if (ud) begin
          m_wrap = (m_val == MAX_VAL);
          m_val  = (m_val + 1) % (MAX_VAL + 1);
        end else begin
          m_wrap = (m_val == 0);
          m_val  = (m_val + MAX_VAL) % (MAX_VAL + 1);
        end
      end
      if (cl) begin
        m_mode = 0; m_val = 0;
      end else if (sp) begin
        if (m_mode == 1) m_mode = 2;
      end else if (st) begin
        m_mode = 1;
      end
      m_run = (m_mode == 1);
    end
    #1;
  endtask

  // lo cycles low then hi cycles high; the tick lands on the first high cycle.
  task automatic rise(input int lo, input int hi, input bit ud);
    for (int i = 0; i < lo; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ud);
    for (int i = 0; i < hi; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ud);
  endtask

  task automatic test_reset();
    logic [23:0] idle_v;
    idle_v = {8'h00, 2'b00, 7'b1000000, 7'b1000000};
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, i[0], 1'b0, 1'b0, 1'b0, 1'b1);
      total++;
      if (got() !== idle_v) begin bad++; $display("FAIL reset_state: got %h want %h", got(), idle_v); end
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, i[0], 1'b0, 1'b0, 1'b0, 1'b1);
      total++;
      if (got() !== idle_v) begin bad++; $display("FAIL idle_hold: got %h want %h", got(), idle_v); end
    end
  endtask

  task automatic test_up_count();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 11; i++) begin
      rise(25, 25, 1'b1);
      total++;
      if (got() !== exp_vec()) begin bad++; $display("FAIL up_step: got %h want %h", got(), exp_vec()); end
    end
    rise(25, 1, 1'b1);
    total++;
    if ({bus.tens, bus.ones, bus.seg_tens, bus.seg_ones} !== {8'h12, 7'b1111001, 7'b1111001}) begin
      bad++; $display("FAIL up_twelve: got %h%h want 12", bus.tens, bus.ones);
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if ({bus.seg_tens, bus.seg_ones} !== {7'b1111001, 7'b0100100}) begin
      bad++; $display("FAIL up_seg: got %b %b want 1111001 0100100", bus.seg_tens, bus.seg_ones);
    end
  endtask

  task automatic test_wrap_up();
    for (int i = 0; i < 47; i++) rise(1, 1, 1'b1);
    total++;
    if ({bus.tens, bus.ones, bus.wrap} !== {8'h59, 1'b0}) begin
      bad++; $display("FAIL up_59: got %h%h want 59", bus.tens, bus.ones);
    end
    rise(1, 1, 1'b1);
    total++;
    if ({bus.tens, bus.ones, bus.wrap} !== {8'h00, 1'b1}) begin
      bad++; $display("FAIL up_wrap: got %h%h w%b want 00 w1", bus.tens, bus.ones, bus.wrap);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (bus.wrap !== 1'b0) begin bad++; $display("FAIL wrap_width: got %b want 0", bus.wrap); end
    rise(0, 1, 1'b1);
    total++;
    if ({bus.tens, bus.ones, bus.wrap} !== {8'h01, 1'b0}) begin
      bad++; $display("FAIL up_after_wrap: got %h%h w%b want 01 w0", bus.tens, bus.ones, bus.wrap);
    end
  endtask

  task automatic test_wrap_down();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    rise(1, 1, 1'b0);
    total++;
    if ({bus.tens, bus.ones, bus.wrap} !== {8'h59, 1'b1}) begin
      bad++; $display("FAIL down_wrap: got %h%h w%b want 59 w1", bus.tens, bus.ones, bus.wrap);
    end
    rise(1, 1, 1'b0);
    total++;
    if ({bus.tens, bus.ones, bus.wrap} !== {8'h58, 1'b0}) begin
      bad++; $display("FAIL down_58: got %h%h w%b want 58 w0", bus.tens, bus.ones, bus.wrap);
    end
    total++;
    if (got() !== exp_vec()) begin bad++; $display("FAIL down_model: got %h want %h", got(), exp_vec()); end
  endtask

  task automatic test_priority();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) rise(1, 1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    total++;
    if ({bus.tens, bus.ones, bus.running, bus.wrap} !== {8'h00, 2'b00}) begin
      bad++; $display("FAIL stop_clear: got %h%h r%b want 00 r0", bus.tens, bus.ones, bus.running);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) rise(1, 1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    total++;
    if (bus.running !== 1'b0) begin bad++; $display("FAIL start_stop_pause: got %b want 0", bus.running); end
    rise(1, 1, 1'b1);
    total++;
    if ({bus.tens, bus.ones, bus.running} !== {8'h03, 1'b0}) begin
      bad++; $display("FAIL pause_hold: got %h%h r%b want 03 r0", bus.tens, bus.ones, bus.running);
    end
  endtask

  task automatic test_mid_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 34; i++) rise(1, 1, 1'b1);
    total++;
    if ({bus.tens, bus.ones, bus.running} !== {8'h34, 1'b1}) begin
      bad++; $display("FAIL pre_reset: got %h%h r%b want 34 r1", bus.tens, bus.ones, bus.running);
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if ({bus.tens, bus.ones, bus.running, bus.wrap} !== {8'h00, 2'b00}) begin
      bad++; $display("FAIL mid_reset: got %h%h r%b want 00 r0", bus.tens, bus.ones, bus.running);
    end
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if ({bus.tens, bus.ones, bus.running} !== {8'h00, 1'b1}) begin
      bad++; $display("FAIL no_false_edge: got %h%h r%b want 00 r1", bus.tens, bus.ones, bus.running);
    end
    rise(1, 1, 1'b1);
    total++;
    if ({bus.tens, bus.ones} !== 8'h01) begin
      bad++; $display("FAIL first_real_edge: got %h%h want 01", bus.tens, bus.ones);
    end
  endtask

  task automatic test_random();
    bit ud;
    ud = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 63) == 0) ud = ~ud;
      cyc($urandom_range(0, 299) == 0, 1'($urandom_range(0, 1)),
          $urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
          $urandom_range(0, 149) == 0, ud);
      total++;
      if (got() !== exp_vec()) begin
        bad++; $display("FAIL random_cycle%0d: got %h want %h", i, got(), exp_vec());
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    m_val = 0; m_mode = 0; m_prev = 1'b1; m_wrap = 1'b0; m_run = 1'b0; m_seg_t = 0; m_seg_o = 0;
    rst = 1'b1; bus.div_in = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0; bus.up_dn = 1'b1;
    test_reset();
    test_up_count();
    test_wrap_up();
    test_wrap_down();
    test_priority();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_tick_counter.md
Name: bcd_tick_counter

Overview:
- Two-digit BCD event counter with 7-segment drive outputs; downstream consumer of the divide-by-50 square wave produced by the clock divider stage.
- Samples the divider output in the same clk domain and counts its rising edges while running.
- Provides start/stop/clear control, up/down direction, a wrap pulse for cascading, and registered active-low segment patterns for the board display.

Parameters:
- MAX_VAL, 59, terminal count; legal 1..99. Count range is 0..MAX_VAL, so 59 gives modulo-60.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- div_in  input  1  divided square wave from divider stage, synchronous to clk
- start  input  1  level; begin or resume counting
- stop  input  1  level; pause counting
- clear  input  1  level; return to 00 and idle
- up_dn  input  1  1 = count up, 0 = count down; sampled on each tick
- ones  output  4  BCD units digit
- tens  output  4  BCD tens digit
- running  output  1  high while in RUN
- wrap  output  1  one-cycle pulse on terminal rollover
- seg_ones  output  7  active-low {g,f,e,d,c,b,a} pattern for ones
- seg_tens  output  7  active-low {g,f,e,d,c,b,a} pattern for tens

Behaviour:
- Reset (rst=1 at posedge clk):
  - state=IDLE, ones=0, tens=0, running=0, wrap=0, div_prev=1
  - seg_ones=seg_tens=7'b1000000
  - div_prev=1 suppresses a false edge if div_in is already high when reset releases.
  - Reset asserted mid-count overrides everything on that edge.
- Edge detect: div_prev <= div_in every cycle. tick = div_in & ~div_prev (combinational, one cycle wide).
- FSM states: IDLE, RUN, PAUSE. Control priority: clear > stop > start.
  - Any state with clear=1 -> IDLE; ones=tens=0 on the same edge.
  - IDLE with start=1 -> RUN.
  - RUN with stop=1 -> PAUSE.
  - PAUSE with start=1 -> RUN.
  - Otherwise hold state.
  - running is registered and equals (next_state==RUN).
- Counting:
  - Only when the current state is RUN, tick=1, and no clear/stop this cycle. A tick coinciding with stop or clear is dropped.
  - A tick in the same cycle as the IDLE->RUN transition is not counted.
  - Count updates on the edge that samples tick: 1 clk latency from div_in rising to new ones/tens.
- Up (up_dn=1):
  - value==MAX_VAL -> 00, wrap=1.
  - else if ones==9 -> ones=0, tens+1.
  - else ones+1.
- Down (up_dn=0):
  - value==00 -> tens=MAX_VAL/10, ones=MAX_VAL%10, wrap=1.
  - else if ones==0 -> ones=9, tens-1.
  - else ones-1.
- wrap is high for exactly one cycle, the cycle after the rollover edge; otherwise 0.
- Outputs hold in PAUSE. Digits never leave the 0..MAX_VAL range; BCD digits never exceed 9.
- Segment outputs:
  - Registered from ones/tens, so they lag the digits by 1 clk.
  - Encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Codes 10..15 are unreachable; the decoder outputs 1111111 (blank) for them.
- Divider period is 50 clk, so at most one tick per 50 cycles. The block still handles div_in toggling every cycle: at most one count per rising edge.

Test Plan:
- Reset then idle: rst high 2 cycles, div_in toggling, start=0 -> ones=tens=0, running=0, wrap=0, seg_* = 1000000 throughout.
- Up count: start pulse, up_dn=1, 12 div_in rising edges (period 50) -> after the 12th tick, tens=1 and ones=2 one cycle later; seg_tens=1111001 and seg_ones=0100100 one further cycle later.
- Up wrap, MAX_VAL=59: preload by counting to 59, then one tick -> 00 and wrap=1 for exactly 1 cycle. A further tick gives 01 with wrap=0.
- Down wrap: from 00 in RUN, up_dn=0, one tick -> tens=5, ones=9, wrap=1 one cycle. Next tick -> 58.
- Control priority: at count 07 assert stop and clear together, coincident with a tick -> state IDLE, count 00, no increment, running=0. Start+stop together in PAUSE -> stays PAUSE.
- Mid-operation reset: at count 34 in RUN, with div_in high, assert rst one cycle -> count 00, IDLE. On release with div_in still high, no count occurs until the next genuine rising edge after start.
